// File: rtl/board_pkg.sv
// Shared types and widths for the front-panel controller: display state,
// register/byte index widths and the LED byte selector.
package board_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int BYTE_IDX_W = 2;

  typedef enum logic [1:0] {
    SHOW_PC = 2'd0,
    SHOW_R1 = 2'd1,
    SHOW_R2 = 2'd2
  } disp_state_e;

  function automatic logic [7:0] select_byte(input logic [31:0] val,
                                             input logic [BYTE_IDX_W-1:0] idx);
    logic [31:0] sh;
    sh = val >> {idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/board_ctrl_btn_debounce.sv
// Button debouncer: two-flop synchronizer, stability counter, debounced level
// and a one-cycle press pulse on an accepted rising transition.
module btn_debounce #(
  parameter int DEB_CNT = 1000000
) (
  input  logic mainClk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CNT);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_W'(DEB_CNT - 1)) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge mainClk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;

endmodule

// File: rtl/board_ctrl.sv
// Front-panel controller: button debounce, display select FSM, LED byte mux and
// CPU step strobe. Define BOARD_CTRL_STEP_EN to enable the step/run switch path.
module board_ctrl
  import board_pkg::*;
#(
  parameter int DEB_CNT = 1000000,
  parameter int DIV_MAX = 25000000
) (
  input  logic        mainClk,
  input  logic        reset,
  input  logic        chreg1,
  input  logic        chreg2,
  input  logic        chPC,
  input  logic        step,
  input  logic        run,
  input  logic [31:0] reg1_val,
  input  logic [31:0] reg2_val,
  input  logic [31:0] pc_val,
  output logic [4:0]  reg1_sel,
  output logic [4:0]  reg2_sel,
  output logic        cpu_clk_en,
  output logic        clk,
  output logic [7:0]  led
);

  localparam int DIV_W = $clog2(DIV_MAX);

  logic pc_press, r1_press, r2_press;
  logic unused_pc_lvl, unused_r1_lvl, unused_r2_lvl;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_db_pc (
    .mainClk(mainClk), .reset(reset), .raw(chPC),
    .level(unused_pc_lvl), .press(pc_press)
  );
  btn_debounce #(.DEB_CNT(DEB_CNT)) u_db_r1 (
    .mainClk(mainClk), .reset(reset), .raw(chreg1),
    .level(unused_r1_lvl), .press(r1_press)
  );
  btn_debounce #(.DEB_CNT(DEB_CNT)) u_db_r2 (
    .mainClk(mainClk), .reset(reset), .raw(chreg2),
    .level(unused_r2_lvl), .press(r2_press)
  );

  disp_state_e           state_q, state_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;
  logic [REG_IDX_W-1:0]  reg1_sel_q, reg1_sel_d;
  logic [REG_IDX_W-1:0]  reg2_sel_q, reg2_sel_d;
  logic [7:0]            led_q, led_d;
  logic [31:0]           shown_val;

  // chPC outranks chreg1, which outranks chreg2; lower presses are dropped.
  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    reg1_sel_d = reg1_sel_q;
    reg2_sel_d = reg2_sel_q;
    if (pc_press) begin
      if (state_q == SHOW_PC) begin
        byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
      end else begin
        state_d    = SHOW_PC;
        byte_idx_d = '0;
      end
    end else if (r1_press) begin
      if (state_q == SHOW_R1) begin
        reg1_sel_d = reg1_sel_q + REG_IDX_W'(1);
      end else begin
        state_d    = SHOW_R1;
        byte_idx_d = '0;
      end
    end else if (r2_press) begin
      if (state_q == SHOW_R2) begin
        reg2_sel_d = reg2_sel_q + REG_IDX_W'(1);
      end else begin
        state_d    = SHOW_R2;
        byte_idx_d = '0;
      end
    end
  end

  always_comb begin
    shown_val = pc_val;
    case (state_q)
      SHOW_R1: shown_val = reg1_val;
      SHOW_R2: shown_val = reg2_val;
      default: shown_val = pc_val;
    endcase
    led_d = select_byte(shown_val, byte_idx_q);
  end

  logic run_eff, run_chg, step_go;

`ifdef BOARD_CTRL_STEP_EN
  logic run_lvl, step_press, run_prev_q;
  logic unused_run_press, unused_step_lvl;

  btn_debounce #(.DEB_CNT(DEB_CNT)) u_db_step (
    .mainClk(mainClk), .reset(reset), .raw(step),
    .level(unused_step_lvl), .press(step_press)
  );
  btn_debounce #(.DEB_CNT(DEB_CNT)) u_db_run (
    .mainClk(mainClk), .reset(reset), .raw(run),
    .level(run_lvl), .press(unused_run_press)
  );

  always_ff @(posedge mainClk or negedge reset) begin
    if (!reset) run_prev_q <= 1'b0;
    else        run_prev_q <= run_lvl;
  end

  assign run_eff = run_lvl;
  assign run_chg = run_lvl ^ run_prev_q;
  assign step_go = step_press;
`else
  logic unused_step_run;
  assign unused_step_run = step ^ run;
  assign run_eff = 1'b1;
  assign run_chg = 1'b0;
  assign step_go = 1'b0;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic             en_q, en_d;
  logic             clk_q, clk_d;

  // A step press only counts while the divider is parked in single-step mode.
  always_comb begin
    div_d = div_q;
    en_d  = 1'b0;
    if (run_chg) begin
      div_d = '0;
    end else if (run_eff) begin
      if (div_q == DIV_W'(DIV_MAX - 1)) begin
        div_d = '0;
        en_d  = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = '0;
      en_d  = step_go;
    end
    clk_d = clk_q ^ en_d;
  end

  always_ff @(posedge mainClk or negedge reset) begin
    if (!reset) begin
      state_q    <= SHOW_PC;
      byte_idx_q <= '0;
      reg1_sel_q <= '0;
      reg2_sel_q <= '0;
      led_q      <= '0;
      div_q      <= '0;
      en_q       <= 1'b0;
      clk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      reg1_sel_q <= reg1_sel_d;
      reg2_sel_q <= reg2_sel_d;
      led_q      <= led_d;
      div_q      <= div_d;
      en_q       <= en_d;
      clk_q      <= clk_d;
    end
  end

  assign reg1_sel   = reg1_sel_q;
  assign reg2_sel   = reg2_sel_q;
  assign cpu_clk_en = en_q;
  assign clk        = clk_q;
  assign led        = led_q;

endmodule

// File: tb/tb_board_ctrl.sv
// Randomized self-checking bench for board_ctrl against a behavioural model of
// the display selection rules and step-strobe timing.
module tb_board_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;

  logic        mainClk = 1'b0;
  logic        reset = 1'b0;
  logic        chreg1 = 1'b0, chreg2 = 1'b0, chPC = 1'b0, step = 1'b0, run = 1'b0;
  logic [31:0] reg1_val = '0, reg2_val = '0, pc_val = '0;
  logic [4:0]  reg1_sel, reg2_sel;
  logic        cpu_clk_en, clk;
  logic [7:0]  led;

  board_ctrl #(.DEB_CNT(DEB), .DIV_MAX(DIV)) dut (
    .mainClk(mainClk), .reset(reset), .chreg1(chreg1), .chreg2(chreg2),
    .chPC(chPC), .step(step), .run(run), .reg1_val(reg1_val),
    .reg2_val(reg2_val), .pc_val(pc_val), .reg1_sel(reg1_sel),
    .reg2_sel(reg2_sel), .cpu_clk_en(cpu_clk_en), .clk(clk), .led(led)
  );

  always #5 mainClk = ~mainClk;

  int total = 0;
  int bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: display state 0=PC 1=R1 2=R2, byte index, register selects
  int m_state = 0, m_byte = 0, m_r1 = 0, m_r2 = 0;

  task automatic model_press(input logic [2:0] m, input int hold);
    if (hold < DEB) return;
    if (m[0]) begin
      if (m_state == 0) m_byte = (m_byte + 1) % 4;
      else begin m_state = 0; m_byte = 0; end
    end else if (m[1]) begin
      if (m_state == 1) m_r1 = (m_r1 + 1) % 32;
      else begin m_state = 1; m_byte = 0; end
    end else if (m[2]) begin
      if (m_state == 2) m_r2 = (m_r2 + 1) % 32;
      else begin m_state = 2; m_byte = 0; end
    end
  endtask

  function automatic logic [31:0] exp_led();
    logic [31:0] v;
    v = (m_state == 1) ? reg1_val : (m_state == 2) ? reg2_val : pc_val;
    return (v >> (8 * m_byte)) & 32'hFF;
  endfunction

  task automatic check_all(input string tag);
    check_val({tag, "_led"}, 32'(led), exp_led());
    check_val({tag, "_r1sel"}, 32'(reg1_sel), 32'(m_r1));
    check_val({tag, "_r2sel"}, 32'(reg2_sel), 32'(m_r2));
  endtask

  // m = {chreg2, chreg1, chPC}
  task automatic btn(input logic [2:0] m, input int hold);
    @(negedge mainClk);
    {chreg2, chreg1, chPC} = m;
    repeat (hold) @(negedge mainClk);
    {chreg2, chreg1, chPC} = 3'b000;
    repeat (12) @(negedge mainClk);
    model_press(m, hold);
  endtask

  // Strobe monitor: clk parity, free-run period, and silence when required
  int  cyc = 0, pulses = 0, last_pulse = -1;
  bit  fr_check = 1'b0, quiet = 1'b0;

  always @(negedge mainClk) begin
    if (!reset) begin
      pulses = 0;
      last_pulse = -1;
    end else begin
      cyc++;
      if (cpu_clk_en) begin
        pulses++;
        check_val("clk_toggle", 32'(clk), 32'(pulses % 2));
        if (quiet) check_val("quiet_en", 32'(cpu_clk_en), 32'd0);
        if (fr_check && last_pulse >= 0) check_val("period", 32'(cyc - last_pulse), 32'(DIV));
        last_pulse = cyc;
      end
    end
  end

  task automatic count_pulses(input int n, output int cnt);
    int p0;
    p0 = pulses;
    repeat (n) @(negedge mainClk);
    cnt = pulses - p0;
  endtask

  initial begin
    int cnt;
    logic [2:0] m;
    int hold;

    // Reset held low with inputs toggling
    for (int i = 0; i < 16; i++) begin
      @(negedge mainClk);
      {chreg2, chreg1, chPC, step, run} = 5'($urandom);
      pc_val = $urandom;
      #1;
      check_val("rst_led", 32'(led), 32'd0);
      check_val("rst_r1sel", 32'(reg1_sel), 32'd0);
      check_val("rst_r2sel", 32'(reg2_sel), 32'd0);
      check_val("rst_en", 32'(cpu_clk_en), 32'd0);
      check_val("rst_clk", 32'(clk), 32'd0);
    end
    @(negedge mainClk);
    {chreg2, chreg1, chPC, step, run} = 5'b0;
    pc_val = 32'h12345678;
    reg1_val = $urandom;
    reg2_val = $urandom;
    reset = 1'b1;
`ifdef BOARD_CTRL_STEP_EN
    quiet = 1'b1;
`else
    fr_check = 1'b1;
`endif
    @(negedge mainClk);
    check_val("rel_led", 32'(led), 32'h78);
    check_all("rel");

    // Short glitch is rejected
    btn(3'b001, 3);
    check_val("glitch_led", 32'(led), 32'h78);

    // Exact press-to-LED latency: press DEB+2 after raw edge, LED 2 later
    @(negedge mainClk);
    chPC = 1'b1;
    repeat (DEB + 3) @(negedge mainClk);
    check_val("lat_early", 32'(led), 32'h78);
    @(negedge mainClk);
    check_val("lat_led", 32'(led), 32'h56);
    repeat (10 - (DEB + 4)) @(negedge mainClk);
    chPC = 1'b0;
    repeat (12) @(negedge mainClk);
    model_press(3'b001, 10);
    check_all("deb");

    // Byte wrap
    for (int i = 0; i < 4; i++) begin
      btn(3'b001, 10);
      check_all("pcwrap");
    end

    // Register select wrap
    reg1_val = $urandom;
    btn(3'b010, 10);
    check_all("r1_enter");
    for (int i = 0; i < 32; i++) begin
      btn(3'b010, 10);
      check_all("r1_step");
    end

    // Priority: chPC beats chreg2
    btn(3'b100, 10);
    btn(3'b100, 10);
    check_all("r2_step");
    btn(3'b101, 10);
    check_all("prio");

    // Randomized presses, glitches and value changes
    for (int i = 0; i < 40; i++) begin
      m = 3'($urandom_range(1, 7));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DEB - 1) : $urandom_range(DEB, 12);
      reg1_val = $urandom;
      reg2_val = $urandom;
      pc_val = $urandom;
      btn(m, hold);
      check_all("rand");
      @(negedge mainClk);
      pc_val = $urandom;
      reg1_val = $urandom;
      reg2_val = $urandom;
      @(negedge mainClk);
      check_val("val_follow", 32'(led), exp_led());
    end

`ifdef BOARD_CTRL_STEP_EN
    // Single-step: one pulse, one cycle after the step press
    count_pulses(20, cnt);
    check_val("ss_idle", 32'(cnt), 32'd0);
    quiet = 1'b0;
    begin
      int p0;
      p0 = pulses;
      @(negedge mainClk);
      step = 1'b1;
      repeat (DEB + 2) @(negedge mainClk);
      check_val("step_early", 32'(cpu_clk_en), 32'd0);
      @(negedge mainClk);
      check_val("step_lat", 32'(cpu_clk_en), 32'd1);
      @(negedge mainClk);
      check_val("step_one", 32'(cpu_clk_en), 32'd0);
      repeat (4) @(negedge mainClk);
      step = 1'b0;
      repeat (15) @(negedge mainClk);
      check_val("step_count", 32'(pulses - p0), 32'd1);
    end

    // Free-run, with a step press that must be ignored
    run = 1'b1;
    repeat (20) @(negedge mainClk);
    last_pulse = -1;
    fr_check = 1'b1;
    count_pulses(8 * DIV, cnt);
    check_val("fr_count", 32'(cnt), 32'd8);
    step = 1'b1;
    count_pulses(4 * DIV, cnt);
    step = 1'b0;
    check_val("fr_step_ign", 32'(cnt), 32'd4);
    run = 1'b0;
    repeat (20) @(negedge mainClk);
    fr_check = 1'b0;
    quiet = 1'b1;
    count_pulses(30, cnt);
    check_val("back_ss", 32'(cnt), 32'd0);
`else
    // Free-run only: step and run have no effect
    count_pulses(8 * DIV, cnt);
    check_val("fr_count", 32'(cnt), 32'd8);
    run = 1'b1;
    step = 1'b1;
    count_pulses(4 * DIV, cnt);
    check_val("fr_run_ign", 32'(cnt), 32'd4);
    run = 1'b0;
    step = 1'b0;
    count_pulses(4 * DIV, cnt);
    check_val("fr_run0", 32'(cnt), 32'd4);
`endif

    // Mid-operation reset, with a step press in flight
    btn(3'b010, 10);
    btn(3'b010, 10);
    btn(3'b100, 10);
    check_all("pre_rst");
    @(negedge mainClk);
    step = 1'b1;
    repeat (DEB + 1) @(negedge mainClk);
    #1 reset = 1'b0;
    #1;
    check_val("mrst_led", 32'(led), 32'd0);
    check_val("mrst_r1sel", 32'(reg1_sel), 32'd0);
    check_val("mrst_r2sel", 32'(reg2_sel), 32'd0);
    check_val("mrst_en", 32'(cpu_clk_en), 32'd0);
    check_val("mrst_clk", 32'(clk), 32'd0);
    step = 1'b0;
    m_state = 0; m_byte = 0; m_r1 = 0; m_r2 = 0;
    repeat (2) @(negedge mainClk);
    reset = 1'b1;
    @(negedge mainClk);
    check_all("post_rst");
`ifdef BOARD_CTRL_STEP_EN
    count_pulses(20, cnt);
    check_val("no_pending", 32'(cnt), 32'd0);
`else
    count_pulses(4 * DIV, cnt);
    check_val("post_rst_fr", 32'(cnt), 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
